// File: rtl/vga_timing_core.sv
// Parametrised VGA timing generator with a pixel-rate enable, a configurable fetch latency,
// and registered sync/de/rgb outputs aligned to the pixel source.
module vga_timing_core #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter bit HS_POL   = 1'b0,
    parameter bit VS_POL   = 1'b0,
    parameter int COLOR_W  = 12,
    parameter int PIPE_LAT = 2,
    parameter int X_W      = 10,
    parameter int Y_W      = 10
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    output logic [X_W-1:0]     pix_x,
    output logic [Y_W-1:0]     pix_y,
    output logic               pix_req,
    input  logic [COLOR_W-1:0] pixel,
    output logic               hs,
    output logic               vs,
    output logic               de,
    output logic [COLOR_W-1:0] rgb,
    output logic               frame_start,
    output logic               line_start
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    // Flag vector bit positions; all flags are active-high internally.
    localparam int F_DE  = 0;
    localparam int F_HS  = 1;
    localparam int F_VS  = 2;
    localparam int F_SOF = 3;
    localparam int F_SOL = 4;

    logic [X_W-1:0] r_hCnt;
    logic [Y_W-1:0] r_vCnt;
    logic [4:0]     w_raw;
    logic [4:0]     w_stage;
    logic           w_hVis;
    logic           w_vVis;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_hCnt <= '0;
            r_vCnt <= '0;
        end else if (en) begin
            if (r_hCnt == X_W'(H_TOTAL - 1)) begin
                r_hCnt <= '0;
                if (r_vCnt == Y_W'(V_TOTAL - 1))
                    r_vCnt <= '0;
                else
                    r_vCnt <= r_vCnt + 1'b1;
            end else begin
                r_hCnt <= r_hCnt + 1'b1;
            end
        end
    end

    assign w_hVis  = (r_hCnt < X_W'(H_ACTIVE));
    assign w_vVis  = (r_vCnt < Y_W'(V_ACTIVE));
    assign pix_x   = r_hCnt;
    assign pix_y   = r_vCnt;
    assign pix_req = w_hVis && w_vVis;

    always_comb begin
        w_raw        = '0;
        w_raw[F_DE]  = w_hVis && w_vVis;
        w_raw[F_HS]  = (r_hCnt >= X_W'(H_ACTIVE + H_FP)) &&
                       (r_hCnt <  X_W'(H_ACTIVE + H_FP + H_SYNC));
        w_raw[F_VS]  = (r_vCnt >= Y_W'(V_ACTIVE + V_FP)) &&
                       (r_vCnt <  Y_W'(V_ACTIVE + V_FP + V_SYNC));
        w_raw[F_SOF] = (r_hCnt == '0) && (r_vCnt == '0);
        w_raw[F_SOL] = (r_hCnt == '0) && w_vVis;
    end

    // Delay the flags by the source's fetch latency so they meet the matching pixel.
    generate
        if (PIPE_LAT == 0) begin : g_noPipe
            assign w_stage = w_raw;
        end else begin : g_pipe
            logic [4:0] r_pipe [PIPE_LAT];

            always_ff @(posedge clk) begin
                if (rst) begin
                    for (int i = 0; i < PIPE_LAT; i++)
                        r_pipe[i] <= '0;
                end else if (en) begin
                    r_pipe[0] <= w_raw;
                    for (int i = 1; i < PIPE_LAT; i++)
                        r_pipe[i] <= r_pipe[i-1];
                end
            end

            assign w_stage = r_pipe[PIPE_LAT-1];
        end
    endgenerate

    // Strobes drop on any clk without en so they stay one system clock wide.
    always_ff @(posedge clk) begin
        if (rst) begin
            hs          <= ~HS_POL;
            vs          <= ~VS_POL;
            de          <= 1'b0;
            rgb         <= '0;
            frame_start <= 1'b0;
            line_start  <= 1'b0;
        end else if (en) begin
            hs          <= w_stage[F_HS] ? HS_POL : ~HS_POL;
            vs          <= w_stage[F_VS] ? VS_POL : ~VS_POL;
            de          <= w_stage[F_DE];
            rgb         <= w_stage[F_DE] ? pixel : '0;
            frame_start <= w_stage[F_SOF];
            line_start  <= w_stage[F_SOL];
        end else begin
            frame_start <= 1'b0;
            line_start  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_vga_timing_core.sv
// Randomised scoreboard bench for vga_timing_core on a 16x8 total / 8x4 visible raster,
// with a second instance using active-high syncs.
module tb_vga_timing_core;

    localparam int HT  = 16;
    localparam int VT  = 8;
    localparam int LAT = 2;

    typedef struct {
        int         px;
        int         py;
        logic       req;
        logic       de;
        logic       hsAct;
        logic       vsAct;
        logic       fs;
        logic       ls;
        logic [11:0] rgb;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en  = 1'b0;
    logic [11:0] pixel;
    logic [11:0] d1 = '0;
    logic [11:0] d2 = '0;

    logic [9:0]  pixX, pixY, pixX2, pixY2;
    logic        pixReq, hs, vs, de, frameStart, lineStart;
    logic        pixReq2, hs2, vs2, de2, frameStart2, lineStart2;
    logic [11:0] rgb, rgb2;

    exp_t expQ[$];
    int   compared   = 0;
    int   mismatched = 0;
    int   ticks      = 0;

    always #5 clk = ~clk;

    vga_timing_core #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
        .HS_POL(1'b0), .VS_POL(1'b0), .COLOR_W(12), .PIPE_LAT(LAT), .X_W(10), .Y_W(10)
    ) dut (
        .clk(clk), .rst(rst), .en(en),
        .pix_x(pixX), .pix_y(pixY), .pix_req(pixReq), .pixel(pixel),
        .hs(hs), .vs(vs), .de(de), .rgb(rgb),
        .frame_start(frameStart), .line_start(lineStart)
    );

    vga_timing_core #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
        .HS_POL(1'b1), .VS_POL(1'b1), .COLOR_W(12), .PIPE_LAT(LAT), .X_W(10), .Y_W(10)
    ) dutPos (
        .clk(clk), .rst(rst), .en(en),
        .pix_x(pixX2), .pix_y(pixY2), .pix_req(pixReq2), .pixel(pixel),
        .hs(hs2), .vs(vs2), .de(de2), .rgb(rgb2),
        .frame_start(frameStart2), .line_start(lineStart2)
    );

    // Pixel source: returns the {y,x} tag of the coordinate it saw LAT en-ticks ago.
    assign pixel = d2;
    always @(posedge clk) begin
        if (en) begin
            d2 <= d1;
            d1 <= {pixY[3:0], pixX[7:0]};
        end
    end

    // Reference: after n en-ticks since reset the counters show coordinate n, and the
    // outputs show coordinate n-1-LAT (idle if that is negative).
    function automatic exp_t model(int n, bit fresh);
        exp_t e;
        int   m, x, y;
        e.px  = n % HT;
        e.py  = (n / HT) % VT;
        e.req = (e.px < 8) && (e.py < 4);
        m = n - 1 - LAT;
        e.de = 1'b0; e.hsAct = 1'b0; e.vsAct = 1'b0; e.fs = 1'b0; e.ls = 1'b0; e.rgb = '0;
        if (m >= 0) begin
            x = m % HT;
            y = (m / HT) % VT;
            e.de    = (x < 8) && (y < 4);
            e.hsAct = (x >= 10) && (x < 13);
            e.vsAct = (y >= 5) && (y < 7);
            e.fs    = fresh && (x == 0) && (y == 0);
            e.ls    = fresh && (x == 0) && (y < 4);
            e.rgb   = e.de ? 12'((y % 16) * 256 + x) : 12'd0;
        end
        return e;
    endfunction

    task automatic applyStimulus(input logic r, input logic e);
        @(negedge clk);
        rst = r;
        en  = e;
        if (r)
            ticks = 0;
        else if (e)
            ticks++;
        expQ.push_back(model(ticks, e && !r));
    endtask

    task automatic checkOutput(input string name, input int act, input int req);
        compared++;
        if (act != req) begin
            mismatched++;
            $display("[TB] FAIL %s at %0t: got %0d, expected %0d", name, $time, act, req);
        end
    endtask

    // Monitor: one expectation per clock, compared just after the edge it describes.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (expQ.size() > 0) begin
                e = expQ.pop_front();
                checkOutput("pix_x", int'(pixX), e.px);
                checkOutput("pix_y", int'(pixY), e.py);
                checkOutput("pix_req", int'(pixReq), int'(e.req));
                checkOutput("de", int'(de), int'(e.de));
                checkOutput("hs", int'(hs), int'(!e.hsAct));
                checkOutput("vs", int'(vs), int'(!e.vsAct));
                checkOutput("rgb", int'(rgb), int'(e.rgb));
                checkOutput("frame_start", int'(frameStart), int'(e.fs));
                checkOutput("line_start", int'(lineStart), int'(e.ls));
                checkOutput("hs_pos", int'(hs2), int'(e.hsAct));
                checkOutput("vs_pos", int'(vs2), int'(e.vsAct));
                checkOutput("de_pos", int'(de2), int'(e.de));
            end
        end
    end

    initial begin
        $display("[TB] start");
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'(i % 2));
        for (int i = 0; i < 300; i++) applyStimulus(1'b0, 1'b1);
        for (int i = 0; i < 400; i++) applyStimulus(1'b0, (i % 4) == 3);
        for (int i = 0; i < 300; i++) applyStimulus(1'b0, ($urandom_range(0, 2) != 0));
        applyStimulus(1'b1, 1'b1);
        while (ticks != 2 * HT + 5) applyStimulus(1'b0, 1'b1);
        applyStimulus(1'b1, 1'b1);
        applyStimulus(1'b0, 1'b0);
        for (int i = 0; i < 200; i++) applyStimulus(1'b0, 1'b1);
        for (int i = 0; i < 200; i++) applyStimulus($urandom_range(0, 99) == 0, $urandom_range(0, 1) == 1);
        @(posedge clk);
        #3;
        checkOutput("queue_drained", expQ.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
